async_fifo: RTL and testbench

ASYNC_FIFO -- requirements
Module: async_fifo

---
 rtl/async_fifo_pkg.sv | 10 +
 rtl/async_fifo_mem.sv | 42 ++++
 rtl/async_fifo.sv | 90 +++++++++
 tb/tb_async_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared default constants for the single-clock FIFO (async_fifo).
// Optional simulation checkers in async_fifo are compiled only when the
// ASYNC_FIFO_ASSERT_EN macro is defined.
package async_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_ADDR_WIDTH = 4;

endpackage : async_fifo_pkg

// File: rtl/async_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH register array with one synchronous write
// port and one synchronous, registered read port. The array itself is never
// reset; only the read data register is cleared by reset.
module async_fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Store write data; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; holds its value whenever no read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : async_fifo_mem

// File: rtl/async_fifo.sv
// Single-clock FIFO with registered empty/full flags and 1-cycle read latency.
// Pointers are ADDR_WIDTH+1 bits; the extra MSB tells full from empty when
// the address bits match. Define ASYNC_FIFO_ASSERT_EN to compile simulation
// checkers for overflow/underflow requests and contradictory flags.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic                wr_accept;
    logic                rd_accept;

    assign wr_accept = wr_en & ~full_q;
    assign rd_accept = rd_en & ~empty_q;

    // Next pointers and flags; flags are derived from the next pointers so
    // they register in the same cycle as the pointer update.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_accept};
        rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_accept};
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
    end

    // Pointer and flag registers.
    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    async_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk       (wclk),
        .rst_n     (rst),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data_i (data_in),
        .rd_en_i   (rd_accept),
        .rd_addr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_o (data_out)
    );

    assign empty = empty_q;
    assign full  = full_q;

`ifdef ASYNC_FIFO_ASSERT_EN
    // Flag requests the FIFO will drop and any impossible flag combination.
    always @(posedge wclk) begin
        if (rst) begin
            if (wr_en && full_q)
                $error("async_fifo: write request while full");
            if (rd_en && empty_q)
                $error("async_fifo: read request while empty");
            if (full_q && empty_q)
                $error("async_fifo: full and empty both set");
        end
    end
`else
`endif

endmodule : async_fifo

// File: tb/tb_async_fifo.sv
// Directed bench for async_fifo: reset, fill, drain, full/empty boundary
// with simultaneous requests, concurrency, wrap-around and mid-run reset.
module tb_async_fifo;

    logic       wclk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       empty;
    logic       full;

    int n_assert;
    int n_fail;

    async_fifo dut (
        .wclk     (wclk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .data_in  (data_in),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        data_in  = 8'h00;

        // Held reset
        repeat (3) @(posedge wclk);
        #1;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_dout", {24'd0, data_out}, 32'h00);
        rst = 1'b1;
        step();
        check("idle_empty", {31'd0, empty}, 32'd1);

        // 5-unit reset pulse without a clock edge
        rst = 1'b0;
        #1;
        check("pulse_empty", {31'd0, empty}, 32'd1);
        check("pulse_full", {31'd0, full}, 32'd0);
        check("pulse_dout", {24'd0, data_out}, 32'h00);
        #4;
        rst = 1'b1;
        #1;
        check("post_pulse_empty", {31'd0, empty}, 32'd1);
        check("post_pulse_full", {31'd0, full}, 32'd0);
        check("post_pulse_dout", {24'd0, data_out}, 32'h00);

        // Fill with 0x00..0x0F
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            data_in = 8'(i);
            step();
            check("fill_full", {31'd0, full}, (i == 15) ? 32'd1 : 32'd0);
            check("fill_empty", {31'd0, empty}, 32'd0);
        end
        // 17th write is dropped
        data_in = 8'hAA;
        step();
        check("ovf_full", {31'd0, full}, 32'd1);
        // Read+write while full: only the read happens
        rd_en   = 1'b1;
        data_in = 8'hBB;
        step();
        check("full_rw_dout", {24'd0, data_out}, 32'h00);
        check("full_rw_full", {31'd0, full}, 32'd0);
        check("full_rw_empty", {31'd0, empty}, 32'd0);

        // Drain the remaining 15 words
        wr_en = 1'b0;
        for (int i = 1; i < 16; i++) begin
            step();
            check("drain_dout", {24'd0, data_out}, 32'(i));
            check("drain_empty", {31'd0, empty}, (i == 15) ? 32'd1 : 32'd0);
            check("drain_full", {31'd0, full}, 32'd0);
        end
        // Read while empty holds data_out
        step();
        check("udf_dout", {24'd0, data_out}, 32'h0F);
        check("udf_empty", {31'd0, empty}, 32'd1);
        // Read+write while empty: only the write happens
        wr_en   = 1'b1;
        data_in = 8'hCC;
        step();
        check("empty_rw_dout", {24'd0, data_out}, 32'h0F);
        check("empty_rw_empty", {31'd0, empty}, 32'd0);
        check("empty_rw_full", {31'd0, full}, 32'd0);
        wr_en = 1'b0;
        step();
        check("empty_rw_read", {24'd0, data_out}, 32'hCC);
        check("empty_rw_back", {31'd0, empty}, 32'd1);
        rd_en = 1'b0;

        // Concurrency: 5 entries, then 20 cycles of read+write
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 8'h20 + 8'(i);
            step();
        end
        check("conc_pre_empty", {31'd0, empty}, 32'd0);
        check("conc_pre_full", {31'd0, full}, 32'd0);
        rd_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data_in = 8'h25 + 8'(k);
            step();
            check("conc_dout", {24'd0, data_out}, 32'h20 + 32'(k));
            check("conc_empty", {31'd0, empty}, 32'd0);
            check("conc_full", {31'd0, full}, 32'd0);
        end
        wr_en = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            check("conc_tail", {24'd0, data_out}, 32'h34 + 32'(j));
        end
        check("conc_end_empty", {31'd0, empty}, 32'd1);
        rd_en = 1'b0;

        // Wrap-around: 24 words, occupancy never above 8
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'h40 + 8'(i);
            step();
        end
        check("wrap_full8", {31'd0, full}, 32'd0);
        rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            data_in = 8'h48 + 8'(k);
            step();
            check("wrap_mid", {24'd0, data_out}, 32'h40 + 32'(k));
        end
        wr_en = 1'b0;
        for (int j = 0; j < 8; j++) begin
            step();
            check("wrap_tail", {24'd0, data_out}, 32'h50 + 32'(j));
        end
        check("wrap_end_empty", {31'd0, empty}, 32'd1);
        rd_en = 1'b0;

        // Mid-operation reset with 7 entries held
        wr_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_in = 8'h60 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        check("mid_pre_empty", {31'd0, empty}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_full", {31'd0, full}, 32'd0);
        check("mid_rst_dout", {24'd0, data_out}, 32'h00);
        #3;
        rst     = 1'b1;
        wr_en   = 1'b1;
        data_in = 8'h55;
        step();
        check("mid_wr_empty", {31'd0, empty}, 32'd0);
        wr_en = 1'b0;
        rd_en = 1'b1;
        step();
        check("mid_rd_dout", {24'd0, data_out}, 32'h55);
        check("mid_rd_empty", {31'd0, empty}, 32'd1);
        rd_en = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_async_fifo
